// File: rtl/frame_buffer_port_arbiter.sv
// Burst arbiter sharing one single-port frame-buffer memory between the camera
// write controller and the HDMI read controller, with urgency-first priority.
module frame_buffer_port_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int LEVEL_WIDTH = 9,
   parameter int BURST_LEN   = 16,
   parameter int WR_URGENT   = 400,
   parameter int RD_URGENT   = 64
) (
   input  logic                   clk_i,
   input  logic                   resetn_i,
   input  logic                   wr_req_i,
   input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
   input  logic [DATA_WIDTH-1:0]  wr_data_i,
   input  logic [LEVEL_WIDTH-1:0] wr_level_i,
   output logic                   wr_gnt_o,
   input  logic                   rd_req_i,
   input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
   input  logic [LEVEL_WIDTH-1:0] rd_level_i,
   output logic                   rd_gnt_o,
   output logic [DATA_WIDTH-1:0]  rd_data_o,
   output logic                   rd_valid_o,
   output logic                   mem_en_o,
   output logic                   mem_we_o,
   output logic [ADDR_WIDTH-1:0]  mem_addr_o,
   output logic [DATA_WIDTH-1:0]  mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
   output logic [1:0]             owner_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WRITE = 2'b01,
      ST_READ  = 2'b10
   } state_e;

   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam logic [LEVEL_WIDTH-1:0] WR_URG_LVL = LEVEL_WIDTH'(WR_URGENT);
   localparam logic [LEVEL_WIDTH-1:0] RD_URG_LVL = LEVEL_WIDTH'(RD_URGENT);
   localparam logic [CNT_W-1:0]       BURST_MAX  = CNT_W'(BURST_LEN);

   state_e                  state_q, state_d;
   logic                    last_rd_q, last_rd_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    mem_en_q, mem_en_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                    rd_valid_q, rd_valid_d;

   logic             wr_beat, rd_beat, wr_urgent, rd_urgent;
   logic [CNT_W-1:0] cnt_inc;

   assign wr_beat   = (state_q == ST_WRITE) && wr_req_i;
   assign rd_beat   = (state_q == ST_READ)  && rd_req_i;
   assign wr_urgent = wr_level_i >= WR_URG_LVL;
   assign rd_urgent = rd_level_i <  RD_URG_LVL;
   assign cnt_inc   = cnt_q + 1'b1;

   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      last_rd_d   = last_rd_q;
      cnt_d       = cnt_q;
      mem_en_d    = wr_beat || rd_beat;
      mem_we_d    = wr_beat;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_valid_d  = mem_en_q && !mem_we_q;

      if (wr_beat) begin
         mem_addr_d  = wr_addr_i;
         mem_wdata_d = wr_data_i;
      end else if (rd_beat) begin
         mem_addr_d  = rd_addr_i;
      end

      case (state_q)
         ST_IDLE: begin
            // Display underflow is visible, so an urgent read beats an urgent write.
            if (rd_req_i && rd_urgent) begin
               state_d   = ST_READ;
               last_rd_d = 1'b1;
            end else if (wr_req_i && wr_urgent) begin
               state_d   = ST_WRITE;
               last_rd_d = 1'b0;
            end else if (wr_req_i && rd_req_i) begin
               state_d   = last_rd_q ? ST_WRITE : ST_READ;
               last_rd_d = !last_rd_q;
            end else if (wr_req_i) begin
               state_d   = ST_WRITE;
               last_rd_d = 1'b0;
            end else if (rd_req_i) begin
               state_d   = ST_READ;
               last_rd_d = 1'b1;
            end
         end
         ST_WRITE, ST_READ: begin
            if (wr_beat || rd_beat) begin
               cnt_d = cnt_inc;
               if (cnt_inc == BURST_MAX) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q     <= ST_IDLE;
         last_rd_q   <= 1'b1;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_rd_q   <= last_rd_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   assign wr_gnt_o    = wr_beat;
   assign rd_gnt_o    = rd_beat;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rd_valid_o  = rd_valid_q;
   // The memory's own output register supplies the pixel; masking keeps it 0 when idle.
   assign rd_data_o   = rd_valid_q ? mem_rdata_i : '0;
   assign owner_o     = state_q;

endmodule

// File: tb/tb_frame_buffer_port_arbiter.sv
// Randomized scoreboard bench for frame_buffer_port_arbiter with a synchronous
// memory model and a rule-level arbitration reference.
module tb_frame_buffer_port_arbiter;
   localparam int AW = 32, DW = 16, LW = 9, BL = 16, WRU = 400, RDU = 64;

   logic          clk = 1'b0, resetn = 1'b0;
   logic          wr_req = 1'b0, rd_req = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [LW-1:0] wr_level = '0, rd_level = 9'd200;
   logic          wr_gnt_o, rd_gnt_o, rd_valid_o, mem_en_o, mem_we_o;
   logic [DW-1:0] rd_data_o, mem_wdata_o, mem_rdata_i;
   logic [AW-1:0] mem_addr_o;
   logic [1:0]    owner_o;

   frame_buffer_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEVEL_WIDTH(LW),
      .BURST_LEN(BL), .WR_URGENT(WRU), .RD_URGENT(RDU)
   ) dut (
      .clk_i(clk), .resetn_i(resetn),
      .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_level_i(wr_level),
      .wr_gnt_o(wr_gnt_o),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_level_i(rd_level),
      .rd_gnt_o(rd_gnt_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .owner_o(owner_o)
   );

   always #5 clk = ~clk;

   // Synchronous-read frame buffer, 256 words, preloaded with data = address.
   logic [DW-1:0] mem    [256];
   logic [DW-1:0] refmem [256];
   initial begin
      mem_rdata_i = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = DW'(i);
         refmem[i] = DW'(i);
      end
   end
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
         else          mem_rdata_i          <= mem[mem_addr_o[7:0]];
      end
   end

   int errors = 0, checks = 0, cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   typedef struct { int due; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_item_t;
   typedef struct { int due; logic [DW-1:0] data; } rd_item_t;
   wr_item_t wq[$];
   rd_item_t rq[$];

   // Reference: 0 idle, 1 write owner, 2 read owner; last grant remembered as a bit.
   int m_st = 0, m_cnt = 0;
   bit m_last_rd = 1'b1;
   bit wr_adv = 1'b0, rd_adv = 1'b0;

   always @(negedge clk) begin : model
      bit eg_w, eg_r, wu, ru;
      if (!resetn) begin
         m_st = 0; m_cnt = 0; m_last_rd = 1'b1;
         wr_adv = 1'b0; rd_adv = 1'b0;
         wq.delete(); rq.delete();
         for (int i = 0; i < 256; i++) refmem[i] = mem[i];
      end else begin
         eg_w = (m_st == 1) && wr_req;
         eg_r = (m_st == 2) && rd_req;
         check("owner", 64'(owner_o), 64'(m_st));
         check("wr_gnt", 64'(wr_gnt_o), 64'(eg_w));
         check("rd_gnt", 64'(rd_gnt_o), 64'(eg_r));
         wr_adv = wr_gnt_o;
         rd_adv = rd_gnt_o;
         if (eg_w) begin
            wq.push_back('{cyc + 1, wr_addr, wr_data});
            refmem[wr_addr[7:0]] = wr_data;
         end
         if (eg_r) rq.push_back('{cyc + 2, refmem[rd_addr[7:0]]});
         wu = int'(wr_level) >= WRU;
         ru = int'(rd_level) <  RDU;
         if (m_st == 0) begin
            if (rd_req && ru)          m_st = 2;
            else if (wr_req && wu)     m_st = 1;
            else if (wr_req && rd_req) m_st = m_last_rd ? 1 : 2;
            else if (wr_req)           m_st = 1;
            else if (rd_req)           m_st = 2;
            if (m_st != 0) m_last_rd = (m_st == 2);
         end else if (eg_w || eg_r) begin
            m_cnt++;
            if (m_cnt == BL) begin m_st = 0; m_cnt = 0; end
         end else begin
            m_st = 0; m_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin : monitor
      wr_item_t wi;
      rd_item_t ri;
      if (resetn) begin
         check("we_without_en", 64'(mem_we_o & ~mem_en_o), 64'd0);
         if (mem_en_o && mem_we_o) begin
            if (wq.size() == 0) flag("unexpected memory write");
            else begin
               wi = wq.pop_front();
               check("wr_time", 64'(cyc), 64'(wi.due));
               check("wr_addr", 64'(mem_addr_o), 64'(wi.addr));
               check("wr_data", 64'(mem_wdata_o), 64'(wi.data));
            end
         end else if (wq.size() > 0 && wq[0].due <= cyc) begin
            void'(wq.pop_front());
            flag("missing memory write");
         end
         if (rd_valid_o) begin
            if (rq.size() == 0) flag("unexpected rd_valid");
            else begin
               ri = rq.pop_front();
               check("rd_time", 64'(cyc), 64'(ri.due));
               check("rd_data", 64'(rd_data_o), 64'(ri.data));
            end
         end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            void'(rq.pop_front());
            flag("missing rd_valid");
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (wr_adv) begin
         wr_addr = (wr_addr + 1) % 256;
         wr_data = DW'($urandom);
      end
      if (rd_adv) rd_addr = (rd_addr + 1) % 256;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wr_gnt"},   64'(wr_gnt_o),    64'd0);
      check({tag, "_rd_gnt"},   64'(rd_gnt_o),    64'd0);
      check({tag, "_mem_en"},   64'(mem_en_o),    64'd0);
      check({tag, "_mem_we"},   64'(mem_we_o),    64'd0);
      check({tag, "_mem_addr"}, 64'(mem_addr_o),  64'd0);
      check({tag, "_wdata"},    64'(mem_wdata_o), 64'd0);
      check({tag, "_rd_valid"}, 64'(rd_valid_o),  64'd0);
      check({tag, "_rd_data"},  64'(rd_data_o),   64'd0);
      check({tag, "_owner"},    64'(owner_o),     64'd0);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int n;
      bit seen;
      wr_data = DW'($urandom);
      #2;
      check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      #3 resetn = 1'b1;

      // Read-only: preloaded data returns 0,1,2,...
      rd_req = 1'b1; rd_level = 9'd200;
      repeat (40) step();
      rd_req = 1'b0;
      repeat (5) step();

      // Write-only, addresses from 0.
      wr_req = 1'b1; wr_level = 9'd100;
      repeat (40) step();
      wr_req = 1'b0;
      repeat (4) step();

      // Fair sharing with non-urgent levels.
      wr_req = 1'b1; rd_req = 1'b1; wr_level = 9'd100; rd_level = 9'd200;
      repeat (80) step();

      // Both urgent, then only the write side urgent.
      wr_level = 9'd450; rd_level = 9'd30;
      repeat (40) step();
      rd_level = 9'd100;
      repeat (40) step();

      // Early release of a read burst after 5 beats.
      wr_req = 1'b0; rd_req = 1'b0; wr_level = 9'd100; rd_level = 9'd200;
      repeat (4) step();
      rd_req = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && n < 5; i++) begin
         step();
         if (rd_adv) n++;
      end
      if (n < 5) flag("early release: read beats never granted");
      rd_req = 1'b0; wr_req = 1'b1;
      repeat (30) step();

      // Random traffic with level changes mid-burst.
      for (int i = 0; i < 1500; i++) begin
         step();
         if ($urandom_range(0, 7) == 0) wr_req = ~wr_req;
         if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
         if ($urandom_range(0, 3) == 0) wr_level = LW'($urandom_range(0, 511));
         if ($urandom_range(0, 3) == 0) rd_level = LW'($urandom_range(0, 255));
      end

      // Reset in the middle of a write burst after 7 beats.
      wr_req = 1'b0; rd_req = 1'b0; wr_level = 9'd100; rd_level = 9'd200;
      repeat (4) step();
      wr_req = 1'b1;
      n = 0;
      while (!(m_st == 1 && m_cnt == 7) && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) flag("reset test: write burst never reached beat 7");
      #2 resetn = 1'b0;
      #1 check_outputs_zero("async_reset");
      rd_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3 resetn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (wr_gnt_o || rd_gnt_o) begin
            seen = 1'b1;
            check("first_grant_after_reset_is_write", 64'(wr_gnt_o), 64'd1);
         end
      end
      if (!seen) flag("no grant after reset release");
      repeat (40) step();

      wr_req = 1'b0; rd_req = 1'b0;
      repeat (6) step();
      check("write_queue_drained", 64'(wq.size()), 64'd0);
      check("read_queue_drained",  64'(rq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frame_buffer_port_arbiter.md
Name: frame_buffer_port_arbiter

Overview:
- Shares one single-port frame-buffer memory (synchronous read, 1-cycle latency) between two requesters: the camera-side write controller and the HDMI-side read controller.
- Grants the port in bursts. Urgent FIFO levels take priority; otherwise the two sides alternate round-robin.
- Sits between the write/read address controllers and the BRAM/memory wrapper, and drives every memory control, address and data pin.

Parameters:
- ADDR_WIDTH, 32, width of memory address.
- DATA_WIDTH, 16, pixel width (RGB565).
- LEVEL_WIDTH, 9, width of the FIFO level inputs.
- BURST_LEN, 16, maximum beats per grant (≥1).
- WR_URGENT, 400, write side is urgent when wr_level_i ≥ this.
- RD_URGENT, 64, read side is urgent when rd_level_i < this.

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  reset, asynchronous, active-low
- wr_req_i  in  1  write requester has a pixel ready
- wr_addr_i  in  ADDR_WIDTH  write address for the current beat
- wr_data_i  in  DATA_WIDTH  write pixel for the current beat
- wr_level_i  in  LEVEL_WIDTH  input (camera) FIFO fill level
- wr_gnt_o  out  1  beat accepted; requester pops its FIFO and advances its address
- rd_req_i  in  1  read requester wants a pixel
- rd_addr_i  in  ADDR_WIDTH  read address for the current beat
- rd_level_i  in  LEVEL_WIDTH  output (HDMI) FIFO fill level
- rd_gnt_o  out  1  read beat accepted; requester advances its address
- rd_data_o  out  DATA_WIDTH  read pixel
- rd_valid_o  out  1  rd_data_o valid (push into HDMI FIFO)
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_en_o with mem_we_o=0
- owner_o  out  2  current state: 00 IDLE, 01 WRITE, 10 READ

Behaviour:
- Reset values: state IDLE, last_grant = READ, beat count 0; every output 0.
- FSM, states IDLE, WRITE, READ.
  - IDLE lasts exactly one cycle (the turnaround) whenever a request is present.
- Arbitration is evaluated in IDLE only. Priority, highest first:
  1. rd_req_i && rd urgent → READ.
  2. wr_req_i && wr urgent → WRITE.
  3. Both requesting → the side opposite last_grant.
  4. Only one requesting → that side.
  5. None requesting → stay in IDLE.
- Both sides urgent → READ wins, because display underflow is visible.
- last_grant updates on every IDLE→WRITE or IDLE→READ transition.
- WRITE state:
  - wr_gnt_o = wr_req_i (combinational from the state register).
  - On each granted beat, register into the memory outputs next cycle: mem_en_o=1, mem_we_o=1, mem_addr_o=wr_addr_i, mem_wdata_o=wr_data_i.
  - The beat counter increments.
- READ state:
  - rd_gnt_o = rd_req_i.
  - On each granted beat, next cycle: mem_en_o=1, mem_we_o=0, mem_addr_o=rd_addr_i.
  - One cycle after that: rd_valid_o=1, rd_data_o=mem_rdata_i (registered).
  - Grant-to-rd_valid_o latency = 2 cycles, fixed.
- Burst end (→IDLE, counter cleared): the granted beat that makes count == BURST_LEN, or the owner's req deasserted while in its state.
  - A cycle in which the owner's req is low grants nothing and exits the burst.
- Cycles with no beat: mem_en_o=0 and mem_we_o=0. mem_addr_o and mem_wdata_o hold their last value.
- wr_gnt_o and rd_gnt_o are never high in the same cycle. mem_we_o is never high without mem_en_o.
- The read-return pipeline is independent of the FSM. Reads issued in a burst's final beat still return rd_valid_o after the switch to WRITE.
- Urgency inputs are sampled only at the arbitration point. A level change mid-burst does not pre-empt the burst.
- Asynchronous reset mid-burst:
  - All outputs drop to 0 immediately.
  - In-flight read data is discarded (no rd_valid_o).
  - FSM returns to IDLE with last_grant = READ, so the first contended grant after reset goes to WRITE.
- BURST_LEN=1 degenerates to alternating single beats with an IDLE cycle between each.

Test Plan:
- Write-only: wr_req_i held 1, rd_req_i=0, wr_level_i=100, BURST_LEN=16 → bursts of 16 wr_gnt_o, each separated by 1 IDLE cycle; mem_we_o writes addresses 0..15 one cycle after each grant.
- Read-only: rd_req_i=1, rd_level_i=200, memory preloaded with data=addr → rd_valid_o 2 cycles after each rd_gnt_o; rd_data_o follows the sequence 0,1,2,….
- Fair sharing: both requests held, levels non-urgent → WRITE and READ bursts of 16 alternate; first grant after reset is WRITE.
- Urgency: both requesting, wr_level_i=450 (urgent), rd_level_i=30 (urgent) → READ granted. Then rd_level_i=100 → next arbitration grants WRITE regardless of last_grant.
- Early release: rd_req_i drops after 5 beats of a READ burst → rd_gnt_o stops, IDLE for 1 cycle, then WRITE granted; the last 2 rd_valid_o still appear during the turnaround/write.
- Reset mid-WRITE burst at beat 7 → all outputs 0 asynchronously, no stray mem_we_o; after release with both requesting, WRITE granted first.
